mem_req_arbiter: RTL and testbench

Shares one memory-controller request/response path between NUM_REQ requesters (compute units).
- Request side: round-robin arbitration, TID stamping (source index plus per-source sequence number), and writing the packed {TID, rw, addr, data} word into the controller's input FIFO.
- Response side: drains the controller's {TID, data} output FIFO and routes each response back to its source by TID.
- Tracks outstanding requests per source and throttles any source that reaches MAX_OUTSTANDING.

---
 rtl/mem_req_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin request arbiter with TID stamping and response routing
// Shares one memory-controller request/response FIFO pair between NUM_REQ sources.
module mem_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int SRC_WIDTH       = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 31,
    parameter int TID_WIDTH       = 16,
    parameter int CNT_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int REQ_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int DP_DATA_WIDTH   = TID_WIDTH + REQ_WIDTH,
    parameter int VPI_DATA_WIDTH  = TID_WIDTH + DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            req_fifo_wr_en,
    output logic [DP_DATA_WIDTH-1:0]        req_fifo_data,
    input  logic                            req_fifo_full,
    output logic                            rsp_fifo_rd_en,
    input  logic [VPI_DATA_WIDTH-1:0]       rsp_fifo_data,
    input  logic                            rsp_fifo_empty,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [TID_WIDTH-1:0]            rsp_tid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err
);
    localparam int SEQ_WIDTH = TID_WIDTH - SRC_WIDTH;

    logic [SRC_WIDTH-1:0] rr_ptr;
    logic [SEQ_WIDTH-1:0] seq   [NUM_REQ];
    logic [CNT_WIDTH-1:0] outst [NUM_REQ];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   rsp_hit;
    logic [SRC_WIDTH-1:0] grant_idx;
    logic                 grant_any;
    logic                 rsp_take;
    logic [SRC_WIDTH-1:0] rsp_src;
    int                   idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outst[i] < CNT_WIDTH'(MAX_OUTSTANDING))
                          && !req_fifo_full && !reset;
        end
    end

    // First eligible source at or after rr_ptr, wrapping; only the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SRC_WIDTH'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    assign req_ready      = grant;
    assign req_fifo_wr_en = grant_any;
    assign req_fifo_data  = {grant_idx, seq[grant_idx], req_rw[grant_idx],
                             req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH],
                             req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]};

    assign rsp_take       = !rsp_fifo_empty && !reset;
    assign rsp_fifo_rd_en = rsp_take;
    assign rsp_src        = rsp_fifo_data[VPI_DATA_WIDTH-1 -: SRC_WIDTH];

    // A response with no matching in-flight request (or unknown source) matches nothing and is dropped.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_hit[i] = rsp_take && (rsp_src == SRC_WIDTH'(i)) && (outst[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                seq[i]   <= '0;
                outst[i] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    seq[i] <= seq[i] + 1'b1;
                end
                case ({grant[i], rsp_hit[i]})
                    2'b10:   outst[i] <= outst[i] + 1'b1;
                    2'b01:   outst[i] <= outst[i] - 1'b1;
                    default: outst[i] <= outst[i];
                endcase
            end
            rsp_valid <= rsp_hit;
            rsp_err   <= rsp_take && !(|rsp_hit);
            if (|rsp_hit) begin
                rsp_tid  <= rsp_fifo_data[VPI_DATA_WIDTH-1 -: TID_WIDTH];
                rsp_data <= rsp_fifo_data[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter
// Directed vectors with literal expectations plus a per-cycle reference model.
module tb_mem_req_arbiter;
    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int DW  = 32;
    localparam int AW  = 31;
    localparam int TW  = 16;
    localparam int CW  = 4;
    localparam int MAX = 2;
    localparam int DP  = TW + 1 + AW + DW;
    localparam int VP  = TW + DW;
    localparam int SEQ_MOD = 1 << (TW - SW);

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic          req_fifo_wr_en;
    logic [DP-1:0] req_fifo_data;
    logic          req_fifo_full;
    logic          rsp_fifo_rd_en;
    logic [VP-1:0] rsp_fifo_data;
    logic          rsp_fifo_empty;
    logic [N-1:0]  rsp_valid;
    logic [TW-1:0] rsp_tid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    mem_req_arbiter #(
        .NUM_REQ(N), .SRC_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TID_WIDTH(TW), .CNT_WIDTH(CW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .req_fifo_wr_en(req_fifo_wr_en), .req_fifo_data(req_fifo_data),
        .req_fifo_full(req_fifo_full),
        .rsp_fifo_rd_en(rsp_fifo_rd_en), .rsp_fifo_data(rsp_fifo_data),
        .rsp_fifo_empty(rsp_fifo_empty),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DP-1:0] act, input logic [DP-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: per-source in-flight count and sequence, plus expected registered outputs.
    int            m_outst [N];
    int            m_seq   [N];
    int            m_ptr = 0;
    logic [N-1:0]  e_valid = '0;
    logic          e_err   = 1'b0;
    logic [TW-1:0] e_tid   = '0;
    logic [DW-1:0] e_data  = '0;
    int            g;
    int            src;
    logic [N-1:0]  exp_ready;
    logic [DP-1:0] exp_word;

    initial for (int i = 0; i < N; i++) begin m_outst[i] = 0; m_seq[i] = 0; end

    always @(negedge clk) begin
        if (reset) begin
            check("rst_ready", DP'(req_ready), '0);
            check("rst_wr_en", DP'(req_fifo_wr_en), '0);
            check("rst_rd_en", DP'(rsp_fifo_rd_en), '0);
            check("rst_rsp_valid", DP'(rsp_valid), '0);
            check("rst_rsp_err", DP'(rsp_err), '0);
            check("rst_rsp_tid", DP'(rsp_tid), '0);
            check("rst_rsp_data", DP'(rsp_data), '0);
            for (int i = 0; i < N; i++) begin m_outst[i] = 0; m_seq[i] = 0; end
            m_ptr = 0; e_valid = '0; e_err = 1'b0; e_tid = '0; e_data = '0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req_valid[i] && m_outst[i] < MAX && !req_fifo_full) g = i;
            end
            exp_ready = (g >= 0) ? N'(1 << g) : '0;
            check("m_ready", DP'(req_ready), DP'(exp_ready));
            check("m_wr_en", DP'(req_fifo_wr_en), DP'(g >= 0));
            if (g >= 0) begin
                exp_word = {SW'(g), (TW-SW)'(m_seq[g]), req_rw[g],
                            req_addr[g*AW +: AW], req_data[g*DW +: DW]};
                check("m_fifo_data", req_fifo_data, exp_word);
            end
            check("m_rd_en", DP'(rsp_fifo_rd_en), DP'(!rsp_fifo_empty));
            check("m_rsp_valid", DP'(rsp_valid), DP'(e_valid));
            check("m_rsp_err", DP'(rsp_err), DP'(e_err));
            check("m_rsp_tid", DP'(rsp_tid), DP'(e_tid));
            check("m_rsp_data", DP'(rsp_data), DP'(e_data));
            e_valid = '0;
            e_err   = 1'b0;
            if (!rsp_fifo_empty) begin
                src = int'(rsp_fifo_data[VP-1 -: SW]);
                if (src < N && m_outst[src] > 0) begin
                    e_valid = N'(1 << src);
                    e_tid   = rsp_fifo_data[VP-1 -: TW];
                    e_data  = rsp_fifo_data[DW-1:0];
                    m_outst[src]--;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (g >= 0) begin
                m_outst[g]++;
                m_seq[g] = (m_seq[g] + 1) % SEQ_MOD;
                m_ptr    = (g + 1) % N;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic [TW-1:0] tid, input logic [DW-1:0] d);
        rsp_fifo_empty = 1'b0;
        rsp_fifo_data  = {tid, d};
    endtask

    task automatic rsp_none();
        rsp_fifo_empty = 1'b1;
        rsp_fifo_data  = '0;
    endtask

    task automatic reset_pulse();
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
    endtask

    logic [N-1:0]  exp3 [6];
    logic [TW-1:0] drain3 [8];

    initial begin
        exp3   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        drain3 = '{16'h0000, 16'h0001, 16'h4000, 16'h4001, 16'h8000, 16'h8001, 16'hC000, 16'hC001};
        reset = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        req_fifo_full = 1'b0; rsp_fifo_empty = 1'b0; rsp_fifo_data = '0;
        #1 reset = 1'b1;
        #2;
        check("init_rd_en_gated", DP'(rsp_fifo_rd_en), '0);
        check("init_rsp_valid", DP'(rsp_valid), '0);
        rsp_none();
        cyc(); cyc(); reset = 1'b0;

        // Test 1: build up in-flight on source 1, reset mid-traffic, then an orphan response.
        cyc();
        req_valid = 4'b0010; req_addr[1*AW +: AW] = 31'h55; req_data[1*DW +: DW] = 32'h11;
        #3 check("t1_grant0", DP'(req_ready), DP'(4'b0010));
        cyc(); #3 check("t1_grant1", DP'(req_ready), DP'(4'b0010));
        cyc(); #3 check("t1_throttled", DP'(req_ready), DP'(4'b0000));
        cyc(); reset = 1'b1;
        #1 check("t1_rst_ready", DP'(req_ready), '0);
        check("t1_rst_wr_en", DP'(req_fifo_wr_en), '0);
        cyc(); cyc(); reset = 1'b0; req_valid = '0;
        cyc(); rsp(16'h4000, 32'h1234);
        cyc(); rsp_none();
        #3 check("t1_err", DP'(rsp_err), DP'(1'b1));
        check("t1_no_valid", DP'(rsp_valid), '0);

        // Test 2: single source 2 request, TID stamping.
        cyc();
        req_valid = 4'b0100; req_rw[2] = 1'b1;
        req_addr[2*AW +: AW] = 31'h10; req_data[2*DW +: DW] = 32'd7;
        #3 check("t2_ready", DP'(req_ready), DP'(4'b0100));
        check("t2_wr_en", DP'(req_fifo_wr_en), DP'(1'b1));
        check("t2_word", req_fifo_data, {16'h8000, 1'b1, 31'h10, 32'd7});
        cyc(); #3 check("t2_tid1", DP'(req_fifo_data[DP-1 -: TW]), DP'(16'h8001));
        cyc(); req_valid = '0; rsp(16'h8000, 32'hAAAA);
        cyc(); rsp(16'h8001, 32'hBBBB);
        cyc(); rsp_none();
        #3 check("t2_rsp_tid", DP'(rsp_tid), DP'(16'h8001));
        check("t2_rsp_data", DP'(rsp_data), DP'(32'hBBBB));

        // Test 3: round-robin rotation and full backpressure.
        reset_pulse();
        req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            #3 check("t3_rr", DP'(req_ready), DP'(exp3[j]));
            cyc();
        end
        req_fifo_full = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #3 check("t3_full_ready", DP'(req_ready), '0);
            check("t3_full_wr_en", DP'(req_fifo_wr_en), '0);
            cyc();
        end
        req_fifo_full = 1'b0;
        #3 check("t3_resume", DP'(req_ready), DP'(4'b0100));
        cyc(); #3 check("t3_resume2", DP'(req_ready), DP'(4'b1000));
        cyc(); req_valid = '0;
        for (int j = 0; j < 8; j++) begin
            rsp(drain3[j], 32'(j) + 32'h100);
            cyc();
        end
        rsp_none();

        // Test 4: throttle at MAX and release in the response cycle.
        reset_pulse();
        req_valid = 4'b0010;
        #3 check("t4_g0", DP'(req_ready), DP'(4'b0010));
        cyc(); #3 check("t4_g1", DP'(req_ready), DP'(4'b0010));
        cyc(); #3 check("t4_blocked", DP'(req_ready), DP'(4'b0000));
        rsp(16'h4000, 32'hDEADBEEF);
        cyc(); rsp_none();
        #3 check("t4_rsp_valid", DP'(rsp_valid), DP'(4'b0010));
        check("t4_rsp_data", DP'(rsp_data), DP'(32'hDEADBEEF));
        check("t4_release", DP'(req_ready), DP'(4'b0010));
        cyc(); req_valid = '0; rsp(16'h4001, 32'h1);
        cyc(); rsp(16'h4002, 32'h2);
        cyc(); rsp_none();

        // Test 5: grant and response for the same source in one cycle.
        cyc(); req_valid = 4'b1000;
        #3 check("t5_g0", DP'(req_ready), DP'(4'b1000));
        cyc(); rsp(16'hC000, 32'h55);
        #3 check("t5_same_cycle", DP'(req_ready), DP'(4'b1000));
        cyc(); rsp_none();
        #3 check("t5_rsp_valid", DP'(rsp_valid), DP'(4'b1000));
        check("t5_still_ok", DP'(req_ready), DP'(4'b1000));
        cyc(); #3 check("t5_now_full", DP'(req_ready), DP'(4'b0000));
        cyc(); req_valid = '0; rsp(16'hC001, 32'h3);
        cyc(); rsp(16'hC002, 32'h4);
        cyc(); rsp_none();

        // Test 6: sequence number wrap on source 0.
        reset_pulse();
        req_valid = 4'b0001; req_addr[0 +: AW] = 31'h7; req_data[0 +: DW] = 32'h9;
        for (int j = 0; j <= SEQ_MOD; j++) begin
            if (j > 0) rsp({2'b00, (TW-SW)'(j - 1)}, 32'(j));
            else rsp_none();
            #3;
            if (j == SEQ_MOD - 1) check("t6_tid_max", DP'(req_fifo_data[DP-1 -: TW]), DP'(16'h3FFF));
            if (j == SEQ_MOD)     check("t6_tid_wrap", DP'(req_fifo_data[DP-1 -: TW]), DP'(16'h0000));
            cyc();
        end
        req_valid = '0; rsp(16'h0000, 32'hF00D);
        cyc(); rsp_none();
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
